// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps one instruction-memory read in flight and queues the returned
// instructions, each tagged with its byte PC, in a small prefetch FIFO for the decode stage.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       PC_STEP    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned       PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned       CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e            state_q;
    logic              req_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] last_data_q;
    logic [ADDR_W-1:0] last_pc_q;

    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_tgt;

    assign imem_req    = req_q;
    assign imem_addr   = req_addr_q;
    assign instr_valid = (count_q != '0);
    // Outputs fall back to the last presented head so they hold while the FIFO is empty.
    assign instr_out   = instr_valid ? fifo_data[rd_ptr_q] : last_data_q;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr_q] : last_pc_q;

    always_comb begin
        push         = (state_q == StReq) && imem_ack && !redirect_valid;
        pop          = instr_valid && instr_ready;
        count_next   = count_q + CNT_W'(push) - CNT_W'(pop);
        pc_inc       = pc_q + STEP;
        redirect_tgt = redirect_pc & ~ADDR_W'(3);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= imem_data;
            fifo_pc[wr_ptr_q]   <= req_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_q       <= 1'b0;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_data_q <= '0;
            last_pc_q   <= '0;
        end else begin
            if (instr_valid) begin
                last_data_q <= fifo_data[rd_ptr_q];
                last_pc_q   <= fifo_pc[rd_ptr_q];
            end

            // A redirect flushes the buffer and overrides any push or pop this cycle.
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_next;
            end

            unique case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt;
                    end else if (fetch_en && (count_q < FULL_CNT)) begin
                        req_addr_q <= pc_q;
                        req_q      <= 1'b1;
                        state_q    <= StReq;
                    end
                end
                StReq: begin
                    if (imem_ack) begin
                        if (redirect_valid) begin
                            pc_q    <= redirect_tgt;
                            req_q   <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            pc_q <= pc_inc;
                            if (fetch_en && (count_next < FULL_CNT)) begin
                                req_addr_q <= pc_inc;
                            end else begin
                                req_q   <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end else if (redirect_valid) begin
                        // Request cannot be withdrawn; keep it up and drop its data later.
                        pc_q    <= redirect_tgt;
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (redirect_valid) pc_q <= redirect_tgt;
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: generates byte addresses (step 4), issues one outstanding request at a time, and captures returned 8-bit instructions.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports halting via an enable input and PC redirects (branch/jump) that flush the buffer and drop any in-flight response.
- Sits between the PC/branch logic and the decode stage of the 5-stage 8-bit pipeline.

Parameters:
- ADDR_W, 8: byte address / PC width.
- DATA_W, 8: instruction width.
- PC_STEP, 4: byte increment per instruction; memory word index = address/4.
- RESET_PC, 8'h00: first fetch address; must be a multiple of 4.
- FIFO_DEPTH, 2: prefetch buffer entries; power of 2, ≥ 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- fetch_en  input  1  1 = new requests may be started
- redirect_valid  input  1  load new PC and flush, this cycle
- redirect_pc  input  ADDR_W  target PC; bits [1:0] ignored (treated as 00)
- imem_req  output  1  request to instruction memory
- imem_addr  output  ADDR_W  request byte address; stable while imem_req=1
- imem_ack  input  1  memory response valid; may be asserted in the same cycle as imem_req
- imem_data  input  DATA_W  instruction; valid when imem_req && imem_ack
- instr_valid  output  1  FIFO head valid
- instr_ready  input  1  decode accepts the head
- instr_out  output  DATA_W  head instruction
- instr_pc  output  ADDR_W  byte address of the head instruction

Behaviour:
- All state updates on the rising clk edge. Reset is sampled only at the edge, never asynchronously.
- Reset (rst_n=0 at an edge) produces:
  - pc = RESET_PC, req_addr = RESET_PC, FIFO empty (count 0, pointers 0), state IDLE.
  - imem_req = 0, imem_addr = RESET_PC, instr_valid = 0, instr_out = 0, instr_pc = 0.
  - Reset mid-request: the request is abandoned and any later imem_ack while in IDLE is ignored.
- State machine:
  - IDLE: imem_req=0.
    - redirect_valid: pc <= {redirect_pc[7:2],2'b00}, FIFO flushed, stay IDLE.
    - Else if fetch_en && count<FIFO_DEPTH: req_addr <= pc, go REQ.
  - REQ: imem_req=1, imem_addr=req_addr. Held until ack.
    - ack && !redirect_valid: push {imem_data, req_addr}; pc <= pc+PC_STEP (mod 2^ADDR_W; 8'hFC wraps to 8'h00).
      - If fetch_en && count_next<FIFO_DEPTH: req_addr <= pc+PC_STEP, stay REQ (back-to-back, no bubble).
      - Else go IDLE.
    - ack && redirect_valid: data dropped, pc <= redirect target, flush, go IDLE.
    - !ack && redirect_valid: pc <= target, flush, go DISCARD.
    - !ack && !redirect_valid: stay REQ. fetch_en going low does not cancel the request.
  - DISCARD: imem_req=1, imem_addr=old req_addr (a request is never withdrawn before ack).
    - On ack: data dropped, go IDLE.
    - A further redirect_valid updates pc and flushes again; state unchanged.
- FIFO and handshake:
  - Head dequeued when instr_valid && instr_ready.
  - Simultaneous push and pop is allowed; count unchanged.
  - A push never overflows, because a request is issued only when count<FIFO_DEPTH and only one request is outstanding.
  - count_next = count + push − pop.
  - instr_out/instr_pc hold their value while instr_valid=0.
- Priority at a single edge: reset > redirect (flush beats pop and push) > push/pop.
  - instr_valid = 0 in the cycle after a redirect.
- Latency:
  - Zero-wait memory (ack in the same cycle as req): first instr_valid at the 2nd edge after reset release.
  - Steady state: one instruction per cycle while decode is ready.
  - Redirect to first valid of the target instruction: 2 edges, plus memory latency, plus a DISCARD drain if one applies.

Test Plan:
- Reset release, fetch_en=1, zero-wait memory with instrmem[k]=k+8'h10, instr_ready=1 → imem_addr sequence 00,04,08,0C; instr_out 10,11,12,13 on consecutive cycles with instr_pc 00,04,08,0C.
- instr_ready=0 for 5 cycles → exactly 2 entries buffered, imem_req low afterwards; release ready → 10,11 then fetch resumes at 08 with no loss or duplicate.
- Memory ack delayed 3 cycles → imem_req and imem_addr=04 stable across all 3 cycles; one instruction is delivered per ack.
- Redirect to 8'h23 while REQ for 08 is pending (ack 2 cycles later) → state DISCARD, instr_valid=0 next cycle, data from 08 dropped; next request addr 8'h20, instr_pc=20.
- Redirect in the same cycle as ack → the acked data is not delivered; FIFO empty; next imem_addr = target.
- PC 8'hFC fetch → next imem_addr 8'h00 (wrap). rst_n=0 mid-REQ → imem_req=0 next cycle, instr_valid=0, next fetch from 00.
